fc_stream_shell: RTL and testbench

Sequential wrapper that turns the purely combinational fully-connected neuron array into a streaming stage. It deserializes one activation vector from a valid/ready input stream and holds it stable on the neuron inputs. After a fixed settle time it captures every neuron's ReLU output, then serializes those results onto a valid/ready output stream. It sits between the previous layer's output stream and the next layer's input loader.

---
 rtl/fc_pkg.sv | 17 +
 rtl/fc_out_serializer.sv | 50 +++++
 rtl/fc_stream_shell.sv | 120 ++++++++++++
 tb/tb_fc_stream_shell.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared types and default geometry for the fully-connected streaming shell.
package fc_pkg;

    typedef enum logic [1:0] {LOAD, SETTLE, DRAIN} fc_state_e;

    // Result width needed to hold a sum of n products of two width-bit values.
    function automatic int zw(input int width, input int n);
        return width * 2 + $clog2(n);
    endfunction

    localparam int WIDTH      = 8;
    localparam int IN         = 128;
    localparam int N_OUT      = 10;
    localparam int ZW         = zw(WIDTH, IN);
    localparam int SETTLE_CYC = 2;

endpackage

// File: rtl/fc_out_serializer.sv
// Captures every neuron result in one strobe, then walks them out in index
// order on a valid/ready stream. A done pulse marks the final handshake.
module fc_out_serializer #(
    parameter int N_OUT = 10,
    parameter int ZW    = 23
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          capture,
    input  logic [ZW-1:0] z_in [0:N_OUT-1],
    output logic          m_valid,
    input  logic          m_ready,
    output logic [ZW-1:0] m_data,
    output logic          m_last,
    output logic          done
);

    localparam int RW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [RW-1:0] LAST_IDX = RW'(N_OUT - 1);

    logic [ZW-1:0] out_buf [0:N_OUT-1];
    logic [RW-1:0] rd_idx;
    logic          valid_q;

    assign m_valid = valid_q;
    assign m_last  = valid_q && (rd_idx == LAST_IDX);
    // Gated so the bus reads zero while idle rather than the stale last result.
    assign m_data  = valid_q ? out_buf[rd_idx] : '0;
    assign done    = valid_q && m_ready && m_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            rd_idx  <= '0;
            for (int j = 0; j < N_OUT; j++) out_buf[j] <= '0;
        end else if (capture) begin
            valid_q <= 1'b1;
            rd_idx  <= '0;
            for (int j = 0; j < N_OUT; j++) out_buf[j] <= z_in[j];
        end else if (valid_q && m_ready) begin
            if (rd_idx == LAST_IDX) begin
                valid_q <= 1'b0;
                rd_idx  <= '0;
            end else begin
                rd_idx <= rd_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fc_stream_shell.sv
// Streaming wrapper around the combinational neuron array: deserialize one
// activation vector, hold it for a settle window, capture and drain results.
//
//   state  | meaning
//   LOAD   | accepting activation beats into x_vec
//   SETTLE | vector held, waiting for neuron outputs to settle
//   DRAIN  | serializing captured results downstream
module fc_stream_shell
    import fc_pkg::fc_state_e;
#(
    parameter int WIDTH  = fc_pkg::WIDTH,
    parameter int IN     = fc_pkg::IN,
    parameter int N_OUT  = fc_pkg::N_OUT,
    parameter int ZW     = fc_pkg::zw(WIDTH, IN),
    parameter int SETTLE = fc_pkg::SETTLE_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_last,
    output logic [WIDTH-1:0] x_vec [0:IN-1],
    input  logic [ZW-1:0]    z_in  [0:N_OUT-1],
    output logic             m_valid,
    input  logic             m_ready,
    output logic [ZW-1:0]    m_data,
    output logic             m_last,
    output logic             len_err
);

    localparam int IW = $clog2(IN);
    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [IW-1:0] LAST_IDX   = IW'(IN - 1);
    localparam logic [SW-1:0] SETTLE_TOP = SW'(SETTLE - 1);

    fc_state_e     state, state_nxt;
    logic [IW-1:0] wr_idx;
    logic [SW-1:0] settle_cnt;
    logic          s_fire;
    logic          beat_last;
    logic          capture;
    logic          done;

    assign s_fire    = s_valid && s_ready;
    // A beat at the final index closes the frame even without s_last.
    assign beat_last = s_last || (wr_idx == LAST_IDX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= fc_pkg::LOAD;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        capture   = 1'b0;
        unique case (state)
            fc_pkg::LOAD: begin
                s_ready = 1'b1;
                if (s_valid && beat_last) state_nxt = fc_pkg::SETTLE;
            end
            fc_pkg::SETTLE: begin
                if (settle_cnt == '0) begin
                    capture   = 1'b1;
                    state_nxt = fc_pkg::DRAIN;
                end
            end
            fc_pkg::DRAIN: begin
                if (done) state_nxt = fc_pkg::LOAD;
            end
            default: state_nxt = fc_pkg::LOAD;
        endcase
    end

    // Down-counter reloaded outside SETTLE; terminal count triggers capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                       settle_cnt <= SETTLE_TOP;
        else if (state != fc_pkg::SETTLE) settle_cnt <= SETTLE_TOP;
        else if (settle_cnt != '0)        settle_cnt <= settle_cnt - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            len_err <= 1'b0;
        end else begin
            // Error when s_last and the final index disagree.
            len_err <= s_fire && (s_last != (wr_idx == LAST_IDX));
            if (s_fire) wr_idx <= beat_last ? '0 : wr_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < IN; i++) x_vec[i] <= '0;
        end else if (s_fire) begin
            for (int i = 0; i < IN; i++) begin
                if (IW'(i) == wr_idx)                 x_vec[i] <= s_data;
                else if (s_last && (IW'(i) > wr_idx)) x_vec[i] <= '0;
            end
        end
    end

    fc_out_serializer #(
        .N_OUT (N_OUT),
        .ZW    (ZW)
    ) u_ser (
        .clk     (clk),
        .rst_n   (rst_n),
        .capture (capture),
        .z_in    (z_in),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .done    (done)
    );

endmodule

// File: tb/tb_fc_stream_shell.sv
// Scoreboard bench for fc_stream_shell: a stub neuron array derived from x_vec,
// a vector-level reference model, and a decoupled output monitor.
module tb_fc_stream_shell;

    localparam int WIDTH  = 8;
    localparam int IN     = 128;
    localparam int N_OUT  = 10;
    localparam int ZW     = 23;
    localparam int SETTLE = 2;

    logic             clk;
    logic             rst_n;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             s_last;
    logic [WIDTH-1:0] x_vec [0:IN-1];
    logic [ZW-1:0]    z_in  [0:N_OUT-1];
    logic             m_valid;
    logic             m_ready;
    logic [ZW-1:0]    m_data;
    logic             m_last;
    logic             len_err;

    fc_stream_shell #(
        .WIDTH(WIDTH), .IN(IN), .N_OUT(N_OUT), .ZW(ZW), .SETTLE(SETTLE)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .x_vec(x_vec), .z_in(z_in),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .len_err(len_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_count = 0;
    int stub_mode = 0;
    int rdy_mode = 0;
    int rdy_ph = 0;
    int settle_lo = 1;
    int settle_hi = 0;

    logic [WIDTH-1:0] frame_data [0:IN-1];
    logic [WIDTH-1:0] ref_vec    [0:IN-1];
    logic [ZW-1:0]    exp_data_q [$];
    bit               exp_last_q [$];
    int               lat_q [$];
    int               err_q [$];

    // Stub neuron array: mode 0 is a fixed ramp, mode 1 also depends on every activation.
    function automatic logic [ZW-1:0] stub_z(input int j, input int m, input logic [WIDTH-1:0] v [0:IN-1]);
        int s;
        s = j * 1000;
        if (m != 0)
            for (int i = 0; i < IN; i++) s += int'(v[i]) * (((i + j) % 7) + 1);
        return ZW'(s);
    endfunction

    always_comb begin
        for (int j = 0; j < N_OUT; j++) z_in[j] = stub_z(j, stub_mode, x_vec);
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic unexp(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: DUT output with nothing expected (cycle %0d)", nm, cyc);
    endtask

    task automatic check_xvec(input string nm);
        int mism;
        mism = 0;
        for (int i = 0; i < IN; i++) if (x_vec[i] !== ref_vec[i]) mism++;
        chk(nm, mism, 0);
    endtask

    // Sends one frame from frame_data; last_at < 0 means no s_last at all.
    task automatic send_frame(input int last_at, input bit gaps, input bit hold);
        int n;
        int t;
        bit hs;
        n = (last_at >= 0) ? last_at + 1 : IN;
        for (int k = 0; k < n; k++) begin
            if (gaps) begin
                while ($urandom_range(3) == 0) begin
                    s_valid = 1'b0;
                    @(posedge clk); #1;
                end
            end
            s_valid = 1'b1;
            s_data  = frame_data[k];
            s_last  = (k == last_at);
            hs = 1'b0;
            for (int w = 0; w < 300 && !hs; w++) begin
                @(negedge clk);
                if (s_ready) hs = 1'b1;
                else begin @(posedge clk); #1; end
            end
            if (!hs) begin
                $display("FAIL send_timeout: beat %0d never accepted, got s_ready=0, expected 1", k);
                $fatal(1, "input stream stalled");
            end
            t = cyc;
            ref_vec[k] = frame_data[k];
            if (k == n - 1) begin
                if (last_at >= 0)
                    for (int i = last_at + 1; i < IN; i++) ref_vec[i] = '0;
                if (last_at != IN - 1) err_q.push_back(t + 1);
                lat_q.push_back(t + SETTLE + 1);
                settle_lo = t + 1;
                settle_hi = t + SETTLE;
                for (int j = 0; j < N_OUT; j++) begin
                    exp_data_q.push_back(stub_z(j, stub_mode, ref_vec));
                    exp_last_q.push_back(j == N_OUT - 1);
                end
            end
            @(posedge clk); #1;
        end
        s_valid = hold;
        s_last  = 1'b0;
    endtask

    task automatic wait_idle();
        for (int w = 0; w < 2000 && exp_data_q.size() > 0; w++) @(posedge clk);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic random_data();
        for (int i = 0; i < IN; i++) frame_data[i] = WIDTH'($urandom);
    endtask

    // Monitor: pops expectations whenever the DUT presents something.
    initial begin
        bit prev_valid, prev_stall, prev_last, ready_next;
        logic [ZW-1:0] prev_data;
        prev_valid = 0; prev_stall = 0; prev_last = 0; ready_next = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_valid = 0; prev_stall = 0; ready_next = 0;
            end else begin
                if (prev_stall) begin
                    chk("hold_valid", m_valid, 1);
                    chk("hold_data", m_data, prev_data);
                    chk("hold_last", m_last, prev_last);
                end
                if (ready_next) begin
                    chk("s_ready_after_last", s_ready, 1);
                    ready_next = 0;
                end
                if (m_valid) chk("no_overlap_s_ready", s_ready, 0);
                if (cyc >= settle_lo && cyc <= settle_hi) chk("s_ready_in_settle", s_ready, 0);
                if (m_valid && !prev_valid) begin
                    if (lat_q.size() == 0) unexp("first_valid");
                    else chk("first_valid_cycle", cyc, lat_q.pop_front());
                end
                if (m_valid && m_ready) begin
                    if (exp_data_q.size() == 0) unexp("result");
                    else begin
                        chk("m_data", m_data, exp_data_q.pop_front());
                        chk("m_last", m_last, exp_last_q.pop_front());
                    end
                    hs_count++;
                    if (m_last) ready_next = 1;
                end
                if (len_err) begin
                    if (err_q.size() == 0) unexp("len_err");
                    else chk("len_err_cycle", cyc, err_q.pop_front());
                end
                prev_valid = m_valid;
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_last  = m_last;
            end
        end
    end

    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = (rdy_ph == 0) || (rdy_ph == 3);
                default: m_ready = 1'($urandom_range(1));
            endcase
            rdy_ph = (rdy_ph + 1) % 4;
        end
    end

    initial begin
        int base;
        int la;
        rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        for (int i = 0; i < IN; i++) ref_vec[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_last", m_last, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_len_err", len_err, 0);
        check_xvec("rst_xvec");
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Nominal ramp frame against the plain j*1000 stub.
        for (int i = 0; i < IN; i++) frame_data[i] = WIDTH'(i & 8'h7F);
        send_frame(IN - 1, 0, 0);
        check_xvec("xvec_nominal");
        wait_idle();
        stub_mode = 1;

        rdy_mode = 1;
        random_data();
        send_frame(IN - 1, 0, 0);
        check_xvec("xvec_backpressure");
        wait_idle();

        rdy_mode = 0;
        for (int i = 0; i < IN; i++) frame_data[i] = 8'h11;
        send_frame(5, 0, 0);
        check_xvec("xvec_early_last");
        wait_idle();

        random_data();
        send_frame(-1, 0, 0);
        check_xvec("xvec_missing_last");
        random_data();
        rdy_mode = 2;
        send_frame(IN - 1, 1, 0);
        check_xvec("xvec_after_missing");
        wait_idle();

        rdy_mode = 0;
        random_data();
        send_frame(IN - 1, 0, 1);
        check_xvec("xvec_b2b_first");
        random_data();
        send_frame(IN - 1, 0, 1);
        check_xvec("xvec_b2b_second");
        s_valid = 1'b0;
        wait_idle();

        // Reset in the middle of draining.
        rdy_mode = 1;
        base = hs_count;
        random_data();
        send_frame(IN - 1, 0, 0);
        for (int w = 0; w < 200 && hs_count < base + 4; w++) @(posedge clk);
        #3;
        rst_n = 1'b0;
        exp_data_q.delete(); exp_last_q.delete(); lat_q.delete(); err_q.delete();
        settle_lo = 1; settle_hi = 0;
        for (int i = 0; i < IN; i++) ref_vec[i] = '0;
        #1;
        chk("async_rst_m_valid", m_valid, 0);
        chk("async_rst_m_last", m_last, 0);
        chk("async_rst_m_data", m_data, 0);
        chk("async_rst_s_ready", s_ready, 1);
        chk("async_rst_len_err", len_err, 0);
        check_xvec("async_rst_xvec");
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        rdy_mode = 2;
        random_data();
        send_frame(IN - 1, 1, 0);
        check_xvec("xvec_after_reset");
        wait_idle();

        for (int f = 0; f < 4; f++) begin
            random_data();
            case ($urandom_range(3))
                0:       la = -1;
                1:       la = int'($urandom_range(IN - 2));
                default: la = IN - 1;
            endcase
            send_frame(la, 1, 0);
            check_xvec("xvec_random");
            wait_idle();
        end

        chk("results_left", exp_data_q.size(), 0);
        chk("len_err_left", err_q.size(), 0);
        chk("latency_left", lat_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
